vga_timing_gen: RTL

Parametrised VGA raster timing generator: produces horizontal/vertical sync, an active-video qualifier, pixel coordinates and frame/line strobes for any mode described by its porch/sync/active parameters. It sits between the pixel-clock source and the pixel-generation logic. It adds the following to the fixed 800x600 sync block:
- configurable sync polarity;
- a clock enable for divided pixel clocks;
- frame and line start strobes;
- a vertical-blank flag;
- fully registered, mutually aligned outputs.

---
 rtl/vga_timing_gen_pkg.sv | 56 +++++
 rtl/vga_timing_gen_if.sv | 31 +++
 rtl/vga_axis_counter.sv | 58 +++++
 rtl/vga_timing_gen.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/vga_timing_gen_pkg.sv
// ============================================================================
// vga_timing_pkg : standard VGA mode constants and raster total helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package vga_timing_pkg;

   // 800x600 @ 72 Hz, 50 MHz pixel clock
   localparam int M800_H_ACTIVE = 800;
   localparam int M800_H_FP     = 56;
   localparam int M800_H_SYNC   = 120;
   localparam int M800_H_BP     = 64;
   localparam int M800_V_ACTIVE = 600;
   localparam int M800_V_FP     = 37;
   localparam int M800_V_SYNC   = 6;
   localparam int M800_V_BP     = 23;

   // 640x480 @ 60 Hz, 25.175 MHz pixel clock
   localparam int M640_H_ACTIVE = 640;
   localparam int M640_H_FP     = 16;
   localparam int M640_H_SYNC   = 96;
   localparam int M640_H_BP     = 48;
   localparam int M640_V_ACTIVE = 480;
   localparam int M640_V_FP     = 10;
   localparam int M640_V_SYNC   = 2;
   localparam int M640_V_BP     = 33;

   // 1024x768 @ 60 Hz, 65 MHz pixel clock
   localparam int M1024_H_ACTIVE = 1024;
   localparam int M1024_H_FP     = 24;
   localparam int M1024_H_SYNC   = 136;
   localparam int M1024_H_BP     = 160;
   localparam int M1024_V_ACTIVE = 768;
   localparam int M1024_V_FP     = 3;
   localparam int M1024_V_SYNC   = 6;
   localparam int M1024_V_BP     = 29;

   function automatic int axis_total(input int sync, input int bp,
                                     input int active, input int fp);
      return sync + bp + active + fp;
   endfunction

   function automatic int h_total(input int h_sync, input int h_bp,
                                  input int h_active, input int h_fp);
      return axis_total(h_sync, h_bp, h_active, h_fp);
   endfunction

   function automatic int v_total(input int v_sync, input int v_bp,
                                  input int v_active, input int v_fp);
      return axis_total(v_sync, v_bp, v_active, v_fp);
   endfunction

endpackage

`default_nettype wire

// File: rtl/vga_timing_gen_if.sv
// ============================================================================
// vga_timing_gen_if : pixel enable in, raster timing bundle out
// Rev 1.0
// ============================================================================
`default_nettype none

interface vga_timing_gen_if #(
   parameter int CW = 11
);
   logic          ce;
   logic          VGA_HS;
   logic          VGA_VS;
   logic          valid;
   logic          vblank;
   logic [CW-1:0] X;
   logic [CW-1:0] Y;
   logic          line_start;
   logic          frame_start;

   modport master (
      input  ce,
      output VGA_HS, VGA_VS, valid, vblank, X, Y, line_start, frame_start
   );

   modport slave (
      output ce,
      input  VGA_HS, VGA_VS, valid, vblank, X, Y, line_start, frame_start
   );
endinterface

`default_nettype wire

// File: rtl/vga_axis_counter.sv
// ============================================================================
// vga_axis_counter : one raster axis (sync, back porch, active, front porch)
// Rev 1.0
// ============================================================================
`default_nettype none

module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int SYNC   = 120,
   parameter int BP     = 64,
   parameter int ACTIVE = 800,
   parameter int FP     = 56,
   parameter int CW     = 11
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   input  wire logic          inc,
   output logic [CW-1:0]      cnt,
   output logic               wrap,
   output logic               in_sync,
   output logic               in_active
);

   localparam int            TOTAL     = axis_total(SYNC, BP, ACTIVE, FP);
   localparam logic [CW-1:0] LAST      = CW'(TOTAL - 1);
   localparam logic [CW-1:0] SYNC_END  = CW'(SYNC);
   localparam logic [CW-1:0] ACT_START = CW'(SYNC + BP);
   localparam logic [CW-1:0] ACT_END   = CW'(SYNC + BP + ACTIVE);
   localparam logic [CW-1:0] ONE       = CW'(1);

   logic [CW-1:0] cnt_d;
   logic [CW-1:0] cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (inc) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // wrap flags the last count so the next axis can step in the same cycle
   assign cnt       = cnt_q;
   assign wrap      = (cnt_q == LAST);
   assign in_sync   = (cnt_q < SYNC_END);
   assign in_active = (cnt_q >= ACT_START) && (cnt_q < ACT_END);

endmodule

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// ============================================================================
// vga_timing_gen : parametrised VGA raster timing with registered outputs
// Rev 1.0
// ============================================================================
`default_nettype none

module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int   CW       = 11,
   parameter int   H_ACTIVE = M800_H_ACTIVE,
   parameter int   H_FP     = M800_H_FP,
   parameter int   H_SYNC   = M800_H_SYNC,
   parameter int   H_BP     = M800_H_BP,
   parameter int   V_ACTIVE = M800_V_ACTIVE,
   parameter int   V_FP     = M800_V_FP,
   parameter int   V_SYNC   = M800_V_SYNC,
   parameter int   V_BP     = M800_V_BP,
   parameter logic HS_POL   = 1'b1,
   parameter logic VS_POL   = 1'b1
) (
   input  wire logic        VGA_CLK,
   input  wire logic        RST_N,
   vga_timing_gen_if.master vga
);

   localparam logic [CW-1:0] H_START = CW'(H_SYNC + H_BP);
   localparam logic [CW-1:0] V_START = CW'(V_SYNC + V_BP);

   logic [CW-1:0] h_cnt;
   logic [CW-1:0] v_cnt;
   logic          h_wrap;
   logic          v_wrap;
   logic          h_sync;
   logic          v_sync;
   logic          h_act;
   logic          v_act;
   logic          v_inc;

   assign v_inc = vga.ce && h_wrap;

   vga_axis_counter #(
      .SYNC   (H_SYNC),
      .BP     (H_BP),
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP),
      .CW     (CW)
   ) u_h_axis (
      .clk       (VGA_CLK),
      .rst_n     (RST_N),
      .inc       (vga.ce),
      .cnt       (h_cnt),
      .wrap      (h_wrap),
      .in_sync   (h_sync),
      .in_active (h_act)
   );

   vga_axis_counter #(
      .SYNC   (V_SYNC),
      .BP     (V_BP),
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP),
      .CW     (CW)
   ) u_v_axis (
      .clk       (VGA_CLK),
      .rst_n     (RST_N),
      .inc       (v_inc),
      .cnt       (v_cnt),
      .wrap      (v_wrap),
      .in_sync   (v_sync),
      .in_active (v_act)
   );

   logic          hs_d, hs_q;
   logic          vs_d, vs_q;
   logic          valid_d, valid_q;
   logic          vblank_d, vblank_q;
   logic [CW-1:0] x_d, x_q;
   logic [CW-1:0] y_d, y_q;
   logic          line_start_d, line_start_q;
   logic          frame_start_d, frame_start_q;
   logic          act;

   assign act = h_act && v_act;

   // Levels hold while ce is low; strobes drop so a pulse spans one ce only.
   always_comb begin
      hs_d          = hs_q;
      vs_d          = vs_q;
      valid_d       = valid_q;
      vblank_d      = vblank_q;
      x_d           = x_q;
      y_d           = y_q;
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;
      if (vga.ce) begin
         hs_d          = h_sync ? HS_POL : ~HS_POL;
         vs_d          = v_sync ? VS_POL : ~VS_POL;
         valid_d       = act;
         vblank_d      = !v_act;
         x_d           = act ? (h_cnt - H_START) : '0;
         y_d           = act ? (v_cnt - V_START) : '0;
         line_start_d  = (h_cnt == '0);
         frame_start_d = (h_cnt == '0) && (v_cnt == '0);
      end
   end

   always_ff @(posedge VGA_CLK or negedge RST_N) begin
      if (!RST_N) begin
         hs_q          <= ~HS_POL;
         vs_q          <= ~VS_POL;
         valid_q       <= 1'b0;
         vblank_q      <= 1'b1;
         x_q           <= '0;
         y_q           <= '0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         hs_q          <= hs_d;
         vs_q          <= vs_d;
         valid_q       <= valid_d;
         vblank_q      <= vblank_d;
         x_q           <= x_d;
         y_q           <= y_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign vga.VGA_HS      = hs_q;
   assign vga.VGA_VS      = vs_q;
   assign vga.valid       = valid_q;
   assign vga.vblank      = vblank_q;
   assign vga.X           = x_q;
   assign vga.Y           = y_q;
   assign vga.line_start  = line_start_q;
   assign vga.frame_start = frame_start_q;

   // v_wrap only matters inside the vertical counter itself
   logic unused_ok;
   assign unused_ok = v_wrap;

endmodule

`default_nettype wire
